// File: rtl/moving_average_pkg.sv
// rtl/moving_average_pkg.sv - shared types and helpers for the moving-average sequencer
package moving_average_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FLUSH,
      WAIT_SAMPLE,
      STROBE,
      BUSY,
      CAPTURE
   } state_t;

   localparam int FLUSH_CYCLES_DEFAULT = 2;

   function automatic int wd_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/moving_average_sequencer.sv
// rtl/moving_average_sequencer.sv - drives a moving-average core from a free-running ADC stream
module moving_average_sequencer
   import moving_average_pkg::*;
#(
   parameter int DATA_IN_LEN  = 10,
   parameter int FILTER_POWER = 2,
   parameter int TIMEOUT      = 64,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT,
   parameter int CNT_W        = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [DATA_IN_LEN-1:0] adc_data,
   input  logic                   adc_valid,
   output logic [DATA_IN_LEN-1:0] filt_data_in,
   output logic                   filt_strobe_in,
   output logic                   filt_reset,
   input  logic [DATA_IN_LEN-1:0] filt_data_out,
   input  logic                   filt_strobe_out,
   output logic [DATA_IN_LEN-1:0] avg_data,
   output logic                   avg_valid,
   input  logic                   avg_ready,
   output logic                   warm,
   output logic [CNT_W-1:0]       drop_cnt,
   output logic [CNT_W-1:0]       overrun_cnt,
   output logic                   timeout_err
);

   localparam int WD_W = wd_width(TIMEOUT);
   localparam int FL_W = wd_width(FLUSH_CYCLES);
   localparam int WC_W = FILTER_POWER + 1;
   localparam int WIN  = 1 << FILTER_POWER;

   state_t            state, state_n;
   logic [FL_W-1:0]   flush_cnt;
   logic [WD_W-1:0]   wd_cnt;
   logic [WC_W-1:0]   warm_cnt;
   logic              accept, load, drop_inc, ovr_inc, timeout_hit;

   // Watchdog counts BUSY cycles from zero, so firing at TIMEOUT-2 lands FLUSH TIMEOUT cycles after STROBE.
   always_comb begin
      state_n        = state;
      filt_reset     = 1'b0;
      filt_strobe_in = 1'b0;
      accept         = 1'b0;
      load           = 1'b0;
      timeout_hit    = 1'b0;
      case (state)
         IDLE: begin
            filt_reset = 1'b1;
            if (enable) state_n = FLUSH;
         end
         FLUSH: begin
            filt_reset = 1'b1;
            if (flush_cnt == FL_W'(FLUSH_CYCLES - 1)) state_n = WAIT_SAMPLE;
         end
         WAIT_SAMPLE: begin
            if (adc_valid) begin
               accept  = enable;
               state_n = STROBE;
            end
         end
         STROBE: begin
            filt_strobe_in = 1'b1;
            state_n        = BUSY;
         end
         BUSY: begin
            if (filt_strobe_out) begin
               state_n = CAPTURE;
            end else if (wd_cnt == WD_W'(TIMEOUT - 2)) begin
               timeout_hit = enable;
               state_n     = FLUSH;
            end
         end
         CAPTURE: begin
            load    = enable && (warm_cnt >= WC_W'(WIN - 1));
            state_n = WAIT_SAMPLE;
         end
         default: state_n = IDLE;
      endcase
      if (!enable) state_n = IDLE;
   end

   assign drop_inc = enable && adc_valid && (state != WAIT_SAMPLE);
   assign ovr_inc  = load && avg_valid && !avg_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         flush_cnt    <= '0;
         wd_cnt       <= '0;
         warm_cnt     <= '0;
         filt_data_in <= '0;
         avg_data     <= '0;
         avg_valid    <= 1'b0;
         warm         <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state     <= state_n;
         flush_cnt <= (state == FLUSH) ? flush_cnt + FL_W'(1) : '0;

         if (state == STROBE)    wd_cnt <= '0;
         else if (state == BUSY) wd_cnt <= wd_cnt + WD_W'(1);

         if (state == FLUSH)
            warm_cnt <= '0;
         else if ((state == CAPTURE) && (warm_cnt != WC_W'(WIN)))
            warm_cnt <= warm_cnt + WC_W'(1);

         if (accept) filt_data_in <= adc_data;
         if (load)   avg_data     <= filt_data_out;

         if (!enable) begin
            avg_valid   <= 1'b0;
            warm        <= 1'b0;
            timeout_err <= 1'b0;
         end else begin
            if (load)           avg_valid <= 1'b1;
            else if (avg_ready) avg_valid <= 1'b0;
            if (load)                warm <= 1'b1;
            else if (state == FLUSH) warm <= 1'b0;
            if (timeout_hit) timeout_err <= 1'b1;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_drop_cnt (
      .clk (clk),
      .clr (reset),
      .inc (drop_inc),
      .q   (drop_cnt)
   );

   sat_counter #(.W(CNT_W)) u_overrun_cnt (
      .clk (clk),
      .clr (reset),
      .inc (ovr_inc),
      .q   (overrun_cnt)
   );

endmodule

// File: tb/tb_moving_average_sequencer.sv
// tb/tb_moving_average_sequencer.sv - directed bench for the sequencer with a behavioural 4-tap core
module tb_moving_average_sequencer;

   logic       clk = 1'b0;
   logic       reset, enable, adc_valid, avg_ready;
   logic [9:0] adc_data;
   logic [9:0] filt_data_in, filt_data_out, avg_data;
   logic       filt_strobe_in, filt_reset, filt_strobe_out, avg_valid, warm, timeout_err;
   logic [7:0] drop_cnt, overrun_cnt;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   moving_average_sequencer #(
      .DATA_IN_LEN(10), .FILTER_POWER(2), .TIMEOUT(64), .FLUSH_CYCLES(2), .CNT_W(8)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .adc_data        (adc_data),
      .adc_valid       (adc_valid),
      .filt_data_in    (filt_data_in),
      .filt_strobe_in  (filt_strobe_in),
      .filt_reset      (filt_reset),
      .filt_data_out   (filt_data_out),
      .filt_strobe_out (filt_strobe_out),
      .avg_data        (avg_data),
      .avg_valid       (avg_valid),
      .avg_ready       (avg_ready),
      .warm            (warm),
      .drop_cnt        (drop_cnt),
      .overrun_cnt     (overrun_cnt),
      .timeout_err     (timeout_err)
   );

   // Core model: done 5 cycles after strobe, re-reads data_in at done, result registered a cycle later.
   logic [9:0]  w0 = '0, w1 = '0, w2 = '0, core_out = '0;
   logic [2:0]  cc = '0;
   logic        core_stall = 1'b0;
   logic [11:0] core_sum;

   assign core_sum        = 12'(w0) + 12'(w1) + 12'(w2) + 12'(filt_data_in);
   assign filt_strobe_out = (cc == 3'd5) && !core_stall;
   assign filt_data_out   = core_out;

   always_ff @(posedge clk) begin
      if (filt_reset) begin
         cc <= '0; w0 <= '0; w1 <= '0; w2 <= '0; core_out <= '0;
      end else begin
         if (filt_strobe_in)   cc <= 3'd1;
         else if (cc == 3'd5)  cc <= 3'd0;
         else if (cc != 3'd0)  cc <= cc + 3'd1;
         if ((cc == 3'd5) && !core_stall) begin
            core_out <= core_sum[11:2];
            w0 <= w1; w1 <= w2; w2 <= filt_data_in;
         end
      end
   end

   typedef struct {
      logic [9:0] d;
      bit         ready;
      bit         drop;
      bit         ev;
      logic [9:0] ed;
      bit         ew;
      logic [7:0] edrop;
      logic [7:0] eovr;
   } row_t;

   row_t rows [11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic run_row(input row_t r, input string tag);
      avg_ready = r.ready;
      adc_data  = r.d;
      adc_valid = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1) adc_valid = 1'b0;
         if (k == 2 && r.drop) begin
            adc_valid = 1'b1;
            adc_data  = 10'd1023;
         end
         if (k == 3) begin
            adc_valid = 1'b0;
            chk({tag, " hold"}, 32'(filt_data_in), 32'(r.d));
         end
         if (k == 8) begin
            chk({tag, " valid"}, 32'(avg_valid), 32'(r.ev));
            if (r.ev) chk({tag, " data"}, 32'(avg_data), 32'(r.ed));
            chk({tag, " warm"}, 32'(warm), 32'(r.ew));
            chk({tag, " drop"}, 32'(drop_cnt), 32'(r.edrop));
            chk({tag, " ovr"}, 32'(overrun_cnt), 32'(r.eovr));
         end
         if (k == 9 && r.ready && r.ev) chk({tag, " fall"}, 32'(avg_valid), 32'd0);
      end
   endtask

   initial begin
      rows[0]  = '{10'd4,  1'b1, 1'b0, 1'b0, 10'd0,  1'b0, 8'd0, 8'd0};
      rows[1]  = '{10'd8,  1'b1, 1'b0, 1'b0, 10'd0,  1'b0, 8'd0, 8'd0};
      rows[2]  = '{10'd12, 1'b1, 1'b0, 1'b0, 10'd0,  1'b0, 8'd0, 8'd0};
      rows[3]  = '{10'd16, 1'b1, 1'b0, 1'b1, 10'd10, 1'b1, 8'd0, 8'd0};
      rows[4]  = '{10'd20, 1'b1, 1'b0, 1'b1, 10'd14, 1'b1, 8'd0, 8'd0};
      rows[5]  = '{10'd24, 1'b1, 1'b1, 1'b1, 10'd18, 1'b1, 8'd1, 8'd0};
      rows[6]  = '{10'd28, 1'b1, 1'b0, 1'b1, 10'd22, 1'b1, 8'd1, 8'd0};
      rows[7]  = '{10'd32, 1'b0, 1'b0, 1'b1, 10'd26, 1'b1, 8'd1, 8'd0};
      rows[8]  = '{10'd36, 1'b0, 1'b0, 1'b1, 10'd30, 1'b1, 8'd1, 8'd1};
      rows[9]  = '{10'd40, 1'b0, 1'b0, 1'b1, 10'd34, 1'b1, 8'd1, 8'd2};
      rows[10] = '{10'd44, 1'b0, 1'b0, 1'b1, 10'd38, 1'b1, 8'd1, 8'd2};

      reset = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_data = '0; avg_ready = 1'b1;
      tick(); tick();
      chk("rst filt_reset", 32'(filt_reset), 32'd1);
      chk("rst strobe", 32'(filt_strobe_in), 32'd0);
      chk("rst filt_data_in", 32'(filt_data_in), 32'd0);
      chk("rst avg_data", 32'(avg_data), 32'd0);
      chk("rst avg_valid", 32'(avg_valid), 32'd0);
      chk("rst warm", 32'(warm), 32'd0);
      chk("rst drop", 32'(drop_cnt), 32'd0);
      chk("rst ovr", 32'(overrun_cnt), 32'd0);
      chk("rst timeout", 32'(timeout_err), 32'd0);

      reset = 1'b0; enable = 1'b1;
      for (int i = 0; i < 4; i++) tick();

      for (int i = 0; i < 10; i++) run_row(rows[i], $sformatf("row%0d", i));

      // Held result is released one cycle after ready returns.
      chk("ovr latest valid", 32'(avg_valid), 32'd1);
      chk("ovr latest data", 32'(avg_data), 32'd34);
      avg_ready = 1'b1;
      tick();
      chk("ovr release", 32'(avg_valid), 32'd0);
      run_row(rows[10], "row10");

      // Watchdog: stalled core never signals done.
      core_stall = 1'b1;
      adc_data = 10'd50; adc_valid = 1'b1;
      tick();
      adc_valid = 1'b0;
      chk("wd strobe", 32'(filt_strobe_in), 32'd1);
      tick();
      chk("wd strobe once", 32'(filt_strobe_in), 32'd0);
      for (int i = 0; i < 62; i++) tick();
      chk("wd busy reset", 32'(filt_reset), 32'd0);
      chk("wd busy err", 32'(timeout_err), 32'd0);
      tick();
      chk("wd flush1", 32'(filt_reset), 32'd1);
      chk("wd err", 32'(timeout_err), 32'd1);
      tick();
      chk("wd flush2", 32'(filt_reset), 32'd1);
      tick();
      chk("wd flush end", 32'(filt_reset), 32'd0);

      // Enable dropped mid-operation.
      adc_data = 10'd60; adc_valid = 1'b1;
      tick();
      adc_valid = 1'b0;
      tick(); tick();
      chk("en busy reset", 32'(filt_reset), 32'd0);
      chk("en busy valid", 32'(avg_valid), 32'd1);
      enable = 1'b0;
      tick();
      chk("en off reset", 32'(filt_reset), 32'd1);
      chk("en off valid", 32'(avg_valid), 32'd0);
      chk("en off err", 32'(timeout_err), 32'd0);
      chk("en off warm", 32'(warm), 32'd0);

      // Reset pulsed during BUSY.
      core_stall = 1'b0; enable = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      adc_data = 10'd70; adc_valid = 1'b1;
      tick();
      adc_valid = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid rst filt_reset", 32'(filt_reset), 32'd1);
      chk("mid rst strobe", 32'(filt_strobe_in), 32'd0);
      chk("mid rst filt_data_in", 32'(filt_data_in), 32'd0);
      chk("mid rst avg_data", 32'(avg_data), 32'd0);
      chk("mid rst drop", 32'(drop_cnt), 32'd0);
      chk("mid rst ovr", 32'(overrun_cnt), 32'd0);

      // Continuous samples, consumer stalled: both counters must saturate.
      avg_ready = 1'b0; adc_valid = 1'b1;
      for (int i = 0; i < 2500; i++) begin
         adc_data = 10'(i);
         tick();
      end
      adc_valid = 1'b0;
      tick();
      chk("sat drop", 32'(drop_cnt), 32'd255);
      chk("sat ovr", 32'(overrun_cnt), 32'd255);
      chk("sat valid", 32'(avg_valid), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
